// File: rtl/calc_pkg.sv
// Shared calculator types and helpers.
//   num_t             : signed BCD number (error flag, sign, exponent, mantissa digits)
//   negate_num()      : flips only the sign of a num_t
//   AluTimeoutDefault : default cycle budget for an outstanding ALU operation
package calc_pkg;

    localparam int unsigned NumDigits         = 4;
    localparam int unsigned ExpWidth          = 8;
    localparam int unsigned AluTimeoutDefault = 255;

    typedef logic [3:0] bcd_t;

    typedef struct packed {
        logic                  error;
        logic                  sign;
        logic [ExpWidth-1:0]   exponent;
        bcd_t [NumDigits-1:0]  mant;
    } num_t;

    // Sign flip only; magnitude, exponent and error flag pass through.
    function automatic num_t negate_num(input num_t n);
        num_t r;
        r      = n;
        r.sign = ~n.sign;
        return r;
    endfunction

endpackage

// File: rtl/alu_issue_if.sv
// ALU-side bundle between the issue block and an ALU.
//   op_left/op_right/op_valid/op_ready : operand handshake (issuer -> ALU)
//   res/res_valid/res_ready            : result handshake  (ALU -> issuer)
// Modports: master = issuer side, slave = ALU side.
interface alu_issue_if;
    import calc_pkg::*;

    num_t op_left;
    num_t op_right;
    logic op_valid;
    logic op_ready;
    num_t res;
    logic res_valid;
    logic res_ready;

    modport master (
        output op_left, op_right, op_valid, res_ready,
        input  op_ready, res, res_valid
    );

    modport slave (
        input  op_left, op_right, op_valid, res_ready,
        output op_ready, res, res_valid
    );

endinterface

// File: rtl/alu_issue.sv
// Issues one add/subtract request at a time to an external ALU and holds the
// result for a downstream consumer.
// Ports:
//   clk_i, rst_i (synchronous, active-high)
//   left_i, right_i, op_sub_i, req_valid_i / req_ready_o : request
//   alu_left_o, alu_right_o, alu_valid_o / alu_ready_i   : operands to ALU
//   alu_result_i, alu_valid_i / alu_ready_o              : result from ALU
//   result_o, result_valid_o / result_ready_i            : downstream result
//   timeout_o                                            : last op timed out
// Build option: define ALU_ISSUE_TIMEOUT_EN to abandon an ALU wait after
// TimeoutCycles cycles with an error result.
module alu_issue
    import calc_pkg::*;
#(
    parameter int unsigned TimeoutCycles = AluTimeoutDefault
) (
    input  logic clk_i,
    input  logic rst_i,
    input  num_t left_i,
    input  num_t right_i,
    input  logic op_sub_i,
    input  logic req_valid_i,
    output logic req_ready_o,
    output num_t alu_left_o,
    output num_t alu_right_o,
    output logic alu_valid_o,
    input  logic alu_ready_i,
    input  num_t alu_result_i,
    input  logic alu_valid_i,
    output logic alu_ready_o,
    output num_t result_o,
    output logic result_valid_o,
    input  logic result_ready_i,
    output logic timeout_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_HOLD
    } state_t;

    state_t state;
    num_t   result_q;
    logic   bypass_q;
    num_t   err_num;
    logic   operand_err;

    // Error result: all-zero number with the error flag set.
    always_comb begin
        err_num       = '0;
        err_num.error = 1'b1;
    end

    assign operand_err = alu_left_o.error | alu_right_o.error;

    // Result is only visible while it is being offered.
    assign result_o = result_valid_o ? result_q : '0;

`ifdef ALU_ISSUE_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TimeoutCycles + 1);

    logic [CntW-1:0] wait_cnt;
    logic [CntW-1:0] cnt_inc;
    logic            timeout_hit;

    // Saturating increment; the counter never wraps back to zero.
    assign cnt_inc     = (wait_cnt == {CntW{1'b1}}) ? wait_cnt : wait_cnt + CntW'(1);
    assign timeout_hit = (cnt_inc == CntW'(TimeoutCycles));
`else
    // TimeoutCycles only matters when the timeout is built in.
    logic unused_timeout;
    assign unused_timeout = |TimeoutCycles;
`endif

    // Control FSM with registered handshake outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state          <= S_IDLE;
            req_ready_o    <= 1'b1;
            alu_valid_o    <= 1'b0;
            alu_ready_o    <= 1'b0;
            result_valid_o <= 1'b0;
            timeout_o      <= 1'b0;
            alu_left_o     <= '0;
            alu_right_o    <= '0;
            result_q       <= '0;
            bypass_q       <= 1'b0;
`ifdef ALU_ISSUE_TIMEOUT_EN
            wait_cnt       <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid_i && req_ready_o) begin
                        alu_left_o  <= left_i;
                        alu_right_o <= op_sub_i ? negate_num(right_i) : right_i;
                        // Erroneous operands never reach the ALU.
                        alu_valid_o <= ~(left_i.error | right_i.error);
                        timeout_o   <= 1'b0;
                        req_ready_o <= 1'b0;
                        bypass_q    <= 1'b0;
                        state       <= S_ISSUE;
                    end
                end

                S_ISSUE: begin
                    if (operand_err) begin
                        // One padding cycle keeps the bypass as slow as a zero-latency ALU.
                        bypass_q <= 1'b1;
                        if (bypass_q) begin
                            result_q       <= err_num;
                            result_valid_o <= 1'b1;
                            state          <= S_HOLD;
                        end
                    end else if (alu_valid_o && alu_ready_i) begin
                        alu_valid_o <= 1'b0;
                        alu_ready_o <= 1'b1;
                        state       <= S_WAIT;
`ifdef ALU_ISSUE_TIMEOUT_EN
                        wait_cnt    <= '0;
`endif
                    end
                end

                S_WAIT: begin
`ifdef ALU_ISSUE_TIMEOUT_EN
                    wait_cnt <= cnt_inc;
`endif
                    if (alu_valid_i && alu_ready_o) begin
                        result_q       <= alu_result_i;
                        alu_ready_o    <= 1'b0;
                        result_valid_o <= 1'b1;
                        state          <= S_HOLD;
                    end
`ifdef ALU_ISSUE_TIMEOUT_EN
                    else if (timeout_hit) begin
                        result_q       <= err_num;
                        timeout_o      <= 1'b1;
                        alu_ready_o    <= 1'b0;
                        result_valid_o <= 1'b1;
                        state          <= S_HOLD;
                    end
`endif
                end

                S_HOLD: begin
                    if (result_valid_o && result_ready_i) begin
                        result_valid_o <= 1'b0;
                        req_ready_o    <= 1'b1;
                        state          <= S_IDLE;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 SHALL have parameter TimeoutCycles, default 255, meaning the maximum number of cycles spent waiting for an ALU result.
REQ-002 SHALL have port clk_i, input, 1 bit: the single clock.
REQ-003 SHALL have port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have inputs left_i and right_i, each calc_pkg::num_t: request operands.
REQ-005 SHALL have input op_sub_i, 1 bit: 1 = left minus right, 0 = left plus right.
REQ-006 SHALL have input req_valid_i and output req_ready_o, 1 bit each: request handshake.
REQ-007 SHALL have outputs alu_left_o and alu_right_o, each num_t, plus output alu_valid_o and input alu_ready_i: ALU operand handshake.
REQ-008 SHALL have input alu_result_i (num_t), input alu_valid_i and output alu_ready_o: ALU result handshake.
REQ-009 SHALL have output result_o (num_t), output result_valid_o and input result_ready_i: downstream result handshake.
REQ-010 SHALL have output timeout_o, 1 bit: the last operation timed out.

Function
REQ-011 SHALL drive every output from a flop, except result_o, which is zero whenever result_valid_o is 0.
REQ-012 SHALL implement the states S_IDLE, S_ISSUE, S_WAIT and S_HOLD.
REQ-013 In S_IDLE, SHALL assert req_ready_o=1.
REQ-014 In S_IDLE, on req_valid_i&&req_ready_o, SHALL latch left_i and right_i, invert right.sign when op_sub_i=1, clear timeout_o, drop req_ready_o and go to S_ISSUE.
REQ-015 If the latched left or right error bit is 1, SHALL skip the ALU, set result to '0 with error=1, and go to S_HOLD.
REQ-016 In S_ISSUE, SHALL assert alu_valid_o=1 with the latched operands held stable.
REQ-017 In S_ISSUE, on alu_valid_o&&alu_ready_i, SHALL deassert alu_valid_o the next cycle, clear the wait counter and go to S_WAIT.
REQ-018 In S_WAIT, SHALL assert alu_ready_o=1 and increment the wait counter each cycle.
REQ-019 In S_WAIT, on alu_valid_i&&alu_ready_o, SHALL capture alu_result_i, drop alu_ready_o and go to S_HOLD.
REQ-020 In S_HOLD, SHALL assert result_valid_o=1 with result_o stable until result_ready_i=1.
REQ-021 When result_valid_o&&result_ready_i in S_HOLD, SHALL deassert result_valid_o, assert req_ready_o and go to S_IDLE in the next cycle.
REQ-022 Minimum latency from the request accept to result_valid_o SHALL be (ALU latency)+3 cycles.
REQ-023 SHALL ignore alu_valid_i outside S_WAIT.
REQ-024 SHALL ignore req_valid_i outside S_IDLE.
REQ-025 A request accepted while result_valid_o is being consumed SHALL wait for S_IDLE; there is no back-to-back bypass.
REQ-026 SHALL size the wait counter $clog2(TimeoutCycles+1) bits, saturating with no wrap.

Reset
REQ-027 On rst_i, SHALL set the state to S_IDLE, req_ready_o=1, and alu_valid_o, alu_ready_o, result_valid_o and timeout_o to 0.
REQ-028 On rst_i, SHALL clear all operand, result and counter registers to '0.
REQ-029 Reset asserted mid-operation SHALL abandon the operation; no result is emitted.

Configuration
REQ-030 With ALU_ISSUE_TIMEOUT_EN defined, when the counter reaches TimeoutCycles in S_WAIT, SHALL produce a result of '0 with error=1, set timeout_o=1 and go to S_HOLD.
REQ-031 Without ALU_ISSUE_TIMEOUT_EN, SHALL wait in S_WAIT indefinitely and hold timeout_o at 0, and the counter logic SHALL be absent.

Structure
REQ-032 num_t, bcd_t and NumDigits SHALL come from calc_pkg.
REQ-033 SHALL add to calc_pkg a shared negate_num function (sign flip only) and an AluTimeoutDefault=255 constant.
REQ-034 SHALL be a single module with no sub-module; alu_add is instantiated beside it by the parent, not inside it.

Verification
REQ-035 Add test: left=+12e0, right=+30e0, op_sub_i=0, with alu_add attached -> result_o=+42e0, error=0, result_valid_o held until result_ready_i.
REQ-036 Subtract test: left=+5, right=+7, op_sub_i=1 -> alu_right_o.sign=1, result_o=-2.
REQ-037 Downstream backpressure: result_ready_i=0 for 10 cycles -> result_o is unchanged, req_ready_o=0 throughout, and the next request is accepted only after the handshake.
REQ-038 Error bypass: left.error=1 -> alu_valid_o never asserts, and result_o.error=1 three cycles after the accept.
REQ-039 Timeout with ALU_ISSUE_TIMEOUT_EN and TimeoutCycles=8: alu_valid_i is never asserted -> exactly 8 cycles in S_WAIT, then timeout_o=1 and result_o.error=1; without the macro, the block stays in S_WAIT.
REQ-040 Reset mid-S_WAIT -> the next cycle shows req_ready_o=1 and all valids 0, and a following 1+1 request returns +2.
